// File: rtl/control_unit_if.sv
// Signal bundle between the control unit and the datapath.
// Instruction fields and the zero flag go in; mux selects, strobes and stage pulses come out.
interface control_unit_if;
  logic [1:0] InstructionType;
  logic [4:0] FunctionCode;
  logic       StopBit;
  logic       flag_zero;
  logic [2:0] sig_alu_op;
  logic [1:0] sig_pc_src;
  logic       sig_rb_src;
  logic [1:0] sig_alu_src;
  logic       sig_rf_enable_write;
  logic       sig_enable_data_memory_write;
  logic       sig_enable_data_memory_read;
  logic       sig_write_back_data_select;
  logic       sig_push_return;
  logic       en_instruction_fetch;
  logic       en_instruction_decode;
  logic       en_execute;
  logic       en_memory;
  logic       en_write_back;

  modport master (
    output InstructionType, FunctionCode, StopBit, flag_zero,
    input  sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src, sig_rf_enable_write,
           sig_enable_data_memory_write, sig_enable_data_memory_read,
           sig_write_back_data_select, sig_push_return, en_instruction_fetch,
           en_instruction_decode, en_execute, en_memory, en_write_back
  );

  modport slave (
    input  InstructionType, FunctionCode, StopBit, flag_zero,
    output sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src, sig_rf_enable_write,
           sig_enable_data_memory_write, sig_enable_data_memory_read,
           sig_write_back_data_select, sig_push_return, en_instruction_fetch,
           en_instruction_decode, en_execute, en_memory, en_write_back
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer and decoder: walks INIT/IF/ID/EX/MEM/WB and emits registered
// Moore controls, with the decoded fields captured when the FSM leaves ID.
module control_unit (
  input  logic          clock,
  input  logic          reset_n,
  control_unit_if.slave ctrl
);
  typedef enum logic [2:0] {S_INIT = 3'd0, S_IF = 3'd1, S_ID = 3'd2,
                            S_EX = 3'd3, S_MEM = 3'd4, S_WB = 3'd5} state_t;
  typedef enum logic [2:0] {K_NOP = 3'd0, K_ALU = 3'd1, K_LW = 3'd2,
                            K_SW = 3'd3, K_BEQ = 3'd4, K_JMP = 3'd5} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d, dec_kind;
  logic [2:0] alu_op_q, alu_op_d, dec_alu_op;
  logic [1:0] alu_src_q, alu_src_d, dec_alu_src;
  logic [1:0] pc_src_q, pc_src_d, dec_pc_src;
  logic       rb_src_q, rb_src_d, dec_rb_src;
  logic       wb_sel_q, wb_sel_d, dec_wb_sel;
  logic       stop_q, stop_d;
  logic       dec_jump, dec_jal;
  logic [4:0] en_q, en_d;
  logic       rf_we_q, rf_we_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, push_q, push_d;

  // Decode of the live instruction fields; only consumed while the FSM sits in ID.
  always_comb begin
    dec_kind    = K_NOP;
    dec_alu_op  = 3'b000;
    dec_alu_src = 2'b01;
    dec_rb_src  = 1'b0;
    dec_wb_sel  = 1'b0;
    dec_jump    = 1'b0;
    dec_jal     = 1'b0;
    case (ctrl.InstructionType)
      2'b00: begin
        if (ctrl.FunctionCode < 5'd4) begin
          dec_kind   = K_ALU;
          dec_alu_op = ctrl.FunctionCode[2:0];
        end else begin
          dec_kind = K_NOP;
        end
      end
      2'b01: begin
        case (ctrl.FunctionCode)
          5'd0:    begin dec_kind = K_JMP; dec_jump = 1'b1; end
          5'd1:    begin dec_kind = K_JMP; dec_jump = 1'b1; dec_jal = 1'b1; end
          default: dec_kind = K_NOP;
        endcase
      end
      2'b10: begin
        case (ctrl.FunctionCode)
          5'd0:    begin dec_kind = K_ALU; dec_alu_src = 2'b11; end
          5'd1:    begin dec_kind = K_ALU; dec_alu_op = 3'b001; dec_alu_src = 2'b10; end
          5'd2: begin
            dec_kind = K_LW; dec_alu_op = 3'b001; dec_alu_src = 2'b10; dec_wb_sel = 1'b1;
          end
          5'd3: begin
            dec_kind = K_SW; dec_alu_op = 3'b001; dec_alu_src = 2'b10; dec_rb_src = 1'b1;
          end
          5'd4:    begin dec_kind = K_BEQ; dec_alu_op = 3'b010; dec_rb_src = 1'b1; end
          default: dec_kind = K_NOP;
        endcase
      end
      2'b11: begin
        if (ctrl.FunctionCode < 5'd4) begin
          dec_kind    = K_ALU;
          dec_alu_op  = ctrl.FunctionCode[0] ? 3'b101 : 3'b100;
          dec_alu_src = {1'b0, ctrl.FunctionCode[1]};
        end else begin
          dec_kind = K_NOP;
        end
      end
      default: dec_kind = K_NOP;
    endcase
    dec_pc_src = ctrl.StopBit ? 2'b11 : (dec_jump ? 2'b10 : 2'b00);
  end

  // Next-state logic; BEQ resolves its PC source on the EX->IF edge.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    pc_src_d  = pc_src_q;
    rb_src_d  = rb_src_q;
    wb_sel_d  = wb_sel_q;
    stop_d    = stop_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        kind_d    = dec_kind;
        alu_op_d  = dec_alu_op;
        alu_src_d = dec_alu_src;
        pc_src_d  = dec_pc_src;
        rb_src_d  = dec_rb_src;
        wb_sel_d  = dec_wb_sel;
        stop_d    = ctrl.StopBit;
        if ((dec_kind == K_NOP) || (dec_kind == K_JMP)) begin
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if ((kind_q == K_LW) || (kind_q == K_SW)) begin
          state_d = S_MEM;
        end else if (kind_q == K_BEQ) begin
          state_d  = S_IF;
          pc_src_d = stop_q ? 2'b11 : (ctrl.flag_zero ? 2'b01 : 2'b00);
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (kind_q == K_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_INIT;
    endcase
  end

  // Strobes are computed from the next state so they register in step with it.
  always_comb begin
    en_d     = {state_d == S_IF, state_d == S_ID, state_d == S_EX,
                state_d == S_MEM, state_d == S_WB};
    rf_we_d  = (state_d == S_WB);
    mem_rd_d = (state_d == S_MEM) && (kind_d == K_LW);
    mem_wr_d = (state_d == S_MEM) && (kind_d == K_SW);
    push_d   = (state_q == S_ID) && (state_d == S_IF) && dec_jal;
  end

  // State and output registers, cleared asynchronously so no strobe outlives reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      kind_q    <= K_NOP;
      alu_op_q  <= 3'b000;
      alu_src_q <= 2'b00;
      pc_src_q  <= 2'b00;
      rb_src_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      stop_q    <= 1'b0;
      en_q      <= 5'b00000;
      rf_we_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      pc_src_q  <= pc_src_d;
      rb_src_q  <= rb_src_d;
      wb_sel_q  <= wb_sel_d;
      stop_q    <= stop_d;
      en_q      <= en_d;
      rf_we_q   <= rf_we_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      push_q    <= push_d;
    end
  end

  assign ctrl.sig_alu_op                   = alu_op_q;
  assign ctrl.sig_pc_src                   = pc_src_q;
  assign ctrl.sig_rb_src                   = rb_src_q;
  assign ctrl.sig_alu_src                  = alu_src_q;
  assign ctrl.sig_rf_enable_write          = rf_we_q;
  assign ctrl.sig_enable_data_memory_write = mem_wr_q;
  assign ctrl.sig_enable_data_memory_read  = mem_rd_q;
  assign ctrl.sig_write_back_data_select   = wb_sel_q;
  assign ctrl.sig_push_return              = push_q;
  assign ctrl.en_instruction_fetch         = en_q[4];
  assign ctrl.en_instruction_decode        = en_q[3];
  assign ctrl.en_execute                   = en_q[2];
  assign ctrl.en_memory                    = en_q[1];
  assign ctrl.en_write_back                = en_q[0];
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions against a table-driven
// reference that lists each instruction's stage sequence and control values.
module tb_control_unit;
  logic clock = 1'b0;
  logic reset_n;
  control_unit_if bus ();

  control_unit dut (.clock(clock), .reset_n(reset_n), .ctrl(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [39:0] seq;
    logic [2:0]  len;
    logic [2:0]  op;
    logic [1:0]  src;
    logic        rb;
    logic        wb;
    logic [1:0]  pc;
    logic        push;
    logic        rd;
    logic        wr;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t prev;

  wire [4:0]  en_obs  = {bus.en_instruction_fetch, bus.en_instruction_decode, bus.en_execute,
                         bus.en_memory, bus.en_write_back};
  wire [6:0]  ctl_obs = {bus.sig_alu_op, bus.sig_alu_src, bus.sig_rb_src,
                         bus.sig_write_back_data_select};
  wire [3:0]  str_obs = {bus.sig_rf_enable_write, bus.sig_enable_data_memory_read,
                         bus.sig_enable_data_memory_write, bus.sig_push_return};
  wire [17:0] all_obs = {en_obs, ctl_obs, bus.sig_pc_src, str_obs};

  // Reference: stage letters F/D/E/M/W per instruction plus the decoded controls.
  function automatic exp_t model(input logic [1:0] t, input logic [4:0] f,
                                 input logic s, input logic z);
    exp_t e;
    e     = '0;
    e.src = 2'b01;
    e.seq = "FD";
    e.len = 3'd2;
    case ({t, f})
      {2'b00, 5'd0}: begin e.op = 3'b000; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b00, 5'd1}: begin e.op = 3'b001; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b00, 5'd2}: begin e.op = 3'b010; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b00, 5'd3}: begin e.op = 3'b011; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b10, 5'd0}: begin e.src = 2'b11; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b10, 5'd1}: begin e.op = 3'b001; e.src = 2'b10; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b10, 5'd2}: begin
        e.op = 3'b001; e.src = 2'b10; e.rd = 1'b1; e.wb = 1'b1; e.seq = "FDEMW"; e.len = 3'd5;
      end
      {2'b10, 5'd3}: begin
        e.op = 3'b001; e.src = 2'b10; e.rb = 1'b1; e.wr = 1'b1; e.seq = "FDEM"; e.len = 3'd4;
      end
      {2'b10, 5'd4}: begin
        e.op = 3'b010; e.rb = 1'b1; e.pc = z ? 2'b01 : 2'b00; e.seq = "FDE"; e.len = 3'd3;
      end
      {2'b01, 5'd0}: e.pc = 2'b10;
      {2'b01, 5'd1}: begin e.pc = 2'b10; e.push = 1'b1; end
      {2'b11, 5'd0}: begin e.op = 3'b100; e.src = 2'b00; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b11, 5'd1}: begin e.op = 3'b101; e.src = 2'b00; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b11, 5'd2}: begin e.op = 3'b100; e.seq = "FDEW"; e.len = 3'd4; end
      {2'b11, 5'd3}: begin e.op = 3'b101; e.seq = "FDEW"; e.len = 3'd4; end
      default: e.len = 3'd2;
    endcase
    if (s) e.pc = 2'b11;
    return e;
  endfunction

  function automatic logic [4:0] stage_en(input logic [7:0] st);
    case (st)
      "F":     return 5'b10000;
      "D":     return 5'b01000;
      "E":     return 5'b00100;
      "M":     return 5'b00010;
      "W":     return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Entered on the falling edge of this instruction's IF cycle; leaves at the next IF.
  task automatic exec_instr(input string tag, input logic [1:0] t, input logic [4:0] f,
                            input logic s, input logic z);
    exp_t       e;
    logic [7:0] st;
    e = model(t, f, s, z);
    n_checks++;
    if ({en_obs, bus.sig_pc_src, bus.sig_push_return} !== {5'b10000, prev.pc, prev.push})
      $display("FAIL %s fetch en/pc/push: got %b want %b", tag,
               {en_obs, bus.sig_pc_src, bus.sig_push_return}, {5'b10000, prev.pc, prev.push});
    else n_pass++;
    n_checks++;
    if (ctl_obs !== {prev.op, prev.src, prev.rb, prev.wb})
      $display("FAIL %s held controls: got %b want %b", tag, ctl_obs,
               {prev.op, prev.src, prev.rb, prev.wb});
    else n_pass++;
    bus.InstructionType = t;
    bus.FunctionCode    = f;
    bus.StopBit         = s;
    bus.flag_zero       = z;
    for (int c = 1; c < int'(e.len); c++) begin
      @(negedge clock);
      st = e.seq[8*(int'(e.len)-1-c) +: 8];
      n_checks++;
      if ({en_obs, str_obs} !== {stage_en(st), st == "W", (st == "M") && e.rd,
                                 (st == "M") && e.wr, 1'b0})
        $display("FAIL %s cycle %0d stage/strobes: got %b want %b", tag, c, {en_obs, str_obs},
                 {stage_en(st), st == "W", (st == "M") && e.rd, (st == "M") && e.wr, 1'b0});
      else n_pass++;
      if (c >= 2) begin
        n_checks++;
        if (ctl_obs !== {e.op, e.src, e.rb, e.wb})
          $display("FAIL %s cycle %0d controls: got %b want %b", tag, c, ctl_obs,
                   {e.op, e.src, e.rb, e.wb});
        else n_pass++;
      end
    end
    @(negedge clock);
    prev = e;
  endtask

  task automatic test_reset();
    bus.InstructionType = 2'b00;
    bus.FunctionCode    = 5'd0;
    bus.StopBit         = 1'b0;
    bus.flag_zero       = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (all_obs !== 18'd0) $display("FAIL reset outputs: got %b want 0", all_obs);
      else n_pass++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (all_obs !== {5'b10000, 13'd0})
      $display("FAIL first fetch after reset: got %b want %b", all_obs, {5'b10000, 13'd0});
    else n_pass++;
    prev = '0;
  endtask

  task automatic test_add();
    exec_instr("add", 2'b00, 5'd1, 1'b0, 1'b0);
  endtask

  task automatic test_lw();
    exec_instr("lw", 2'b10, 5'd2, 1'b0, 1'b0);
  endtask

  task automatic test_beq();
    exec_instr("beq_taken", 2'b10, 5'd4, 1'b0, 1'b1);
    exec_instr("beq_not_taken", 2'b10, 5'd4, 1'b0, 1'b0);
  endtask

  task automatic test_jal_stop();
    exec_instr("jal", 2'b01, 5'd1, 1'b0, 1'b0);
    exec_instr("sub_stop", 2'b00, 5'd2, 1'b1, 1'b0);
    exec_instr("illegal_nop", 2'b00, 5'd9, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      exec_instr("random", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 5)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    bus.InstructionType = 2'b10;
    bus.FunctionCode    = 5'd1;
    bus.StopBit         = 1'b0;
    bus.flag_zero       = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({en_obs, bus.sig_rf_enable_write} !== 6'b000011)
      $display("FAIL addi writeback: got %b want 000011", {en_obs, bus.sig_rf_enable_write});
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_obs !== 18'd0) $display("FAIL async abort: got %b want 0", all_obs);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (all_obs !== 18'd0) $display("FAIL held in reset: got %b want 0", all_obs);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (en_obs !== 5'b10000) $display("FAIL refetch after abort: got %b want 10000", en_obs);
    else n_pass++;
    prev = '0;
    exec_instr("post_reset_add", 2'b00, 5'd1, 1'b0, 1'b0);
    exec_instr("flush_j", 2'b01, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jal_stop();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
